// File: rtl/pattern_scan_ctrl.sv
// Frame-based serial pattern scanner: latches a pattern and frame length on start,
// counts overlapping matches over the qualified bits of the frame, then pulses done.
module pattern_scan_ctrl #(
  parameter int PW = 4,
  parameter int LW = 8,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] frame_len,
  input  logic          x,
  input  logic          x_valid,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic [CW-1:0] count,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [CW-1:0] COUNT_MAX = '1;

  state_t        state, state_nxt;
  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] bits_seen;
  logic [PW-2:0] sr;

  logic [PW-1:0] win;
  logic [LW:0]   seen_nxt;
  logic          accept, match, last_bit;

  // NOTE: every combinational output gets a default before any branch, so no latches are inferred.
  always_comb begin
    win      = {sr, x};
    seen_nxt = {1'b0, bits_seen} + (LW+1)'(1);
    accept   = (state == SCAN) && x_valid;
    // Extra bit on seen_nxt keeps the compare exact when frame_len is at its maximum.
    match    = accept && (seen_nxt >= (LW+1)'(PW)) && (win == pat_q);
    last_bit = accept && (seen_nxt == {1'b0, len_q});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (frame_len == '0) ? REPORT : SCAN;
      SCAN:    if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      bits_seen <= '0;
      sr        <= '0;
      hit       <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      hit <= match;
      if (state == IDLE && start) begin
        pat_q     <= pattern;
        len_q     <= frame_len;
        bits_seen <= '0;
        sr        <= '0;
        count     <= '0;
        overflow  <= 1'b0;
      end else if (accept) begin
        sr        <= win[PW-2:0];
        bits_seen <= seen_nxt[LW-1:0];
        if (match) begin
          if (count != COUNT_MAX) count <= count + CW'(1);
          else                    overflow <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == REPORT);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized scoreboard bench for pattern_scan_ctrl; a wide-count and a 2-bit-count
// instance share stimulus and are checked against a window-sliding reference model.
module tb_pattern_scan_ctrl;

  localparam int PW  = 4;
  localparam int LW  = 8;
  localparam int CW  = 10;
  localparam int CWS = 2;

  typedef struct {
    int cnt;
    int ov;
    int cnt_s;
    int ov_s;
  } frame_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          x = 1'b0;
  logic          x_valid = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [LW-1:0] frame_len = '0;

  logic           busy, done, hit, overflow;
  logic [CW-1:0]  count;
  logic           busy_s, done_s, hit_s, overflow_s;
  logic [CWS-1:0] count_s;

  int n_pass  = 0;
  int n_total = 0;

  frame_exp_t exp_frame[$];
  bit         exp_hit[$];

  pattern_scan_ctrl #(.PW(PW), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .frame_len(frame_len),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done), .hit(hit),
    .count(count), .overflow(overflow)
  );

  pattern_scan_ctrl #(.PW(PW), .LW(LW), .CW(CWS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .frame_len(frame_len),
    .x(x), .x_valid(x_valid), .busy(busy_s), .done(done_s), .hit(hit_s),
    .count(count_s), .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: slide a PW-bit window over the frame's bits (first bit = oldest).
  function automatic int model(input logic [PW-1:0] pat, input int len,
                               input logic [63:0] bv, output bit hits[64]);
    int n = 0;
    logic [PW-1:0] w;
    for (int i = 0; i < 64; i++) hits[i] = 1'b0;
    for (int i = PW - 1; i < len; i++) begin
      w = '0;
      for (int j = 0; j < PW; j++) w = {w[PW-2:0], bv[len-1-(i-PW+1+j)]};
      if (w == pat) begin
        hits[i] = 1'b1;
        n++;
      end
    end
    return n;
  endfunction

  // bv holds the frame's bits MSB-first: bit i of the frame is bv[len-1-i].
  task automatic run_frame(input logic [PW-1:0] pat, input int len, input logic [63:0] bv,
                           input int mode, input int start_at, input int abort_at);
    bit         hits[64];
    int         n, i, cyc;
    logic       v;
    frame_exp_t f;
    n       = model(pat, len, bv, hits);
    f.cnt   = (n > 1023) ? 1023 : n;
    f.ov    = (n > 1023) ? 1 : 0;
    f.cnt_s = (n > 3) ? 3 : n;
    f.ov_s  = (n > 3) ? 1 : 0;
    @(negedge clk);
    start     = 1'b1;
    pattern   = pat;
    frame_len = len[LW-1:0];
    if (abort_at < 0) exp_frame.push_back(f);
    i   = 0;
    cyc = 0;
    while (i < len) begin
      @(negedge clk);
      start     = (cyc == start_at);
      pattern   = PW'($urandom);
      frame_len = LW'($urandom);
      if (i == abort_at) begin
        rst     = 1'b1;
        x_valid = 1'b0;
        start   = 1'b0;
        exp_hit.delete();
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_count", {22'b0, count}, 0);
        check("abort_hit", {31'b0, hit}, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom);
      endcase
      x_valid = v;
      x       = v ? bv[len-1-i] : 1'($urandom);
      if (v) begin
        exp_hit.push_back(hits[i]);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    start   = 1'b0;
    x_valid = 1'b0;
    check("frame_reported", exp_frame.size(), 0);
    check("busy_in_report", {31'b0, busy}, 1);
    @(negedge clk);
    check("busy_after_report", {31'b0, busy}, 0);
  endtask

  // Monitor: consume expected hits per accepted bit and expected results per done.
  initial begin : monitor
    frame_exp_t f;
    bit         e;
    @(negedge rst);
    forever begin
      @(posedge clk);
      #1;
      if (exp_hit.size() > 0) begin
        e = exp_hit.pop_front();
        check("hit", {31'b0, hit}, {31'b0, e});
        check("hit_s", {31'b0, hit_s}, {31'b0, e});
      end else begin
        check("hit_quiet", {31'b0, hit}, 0);
      end
      check("done_pair", {31'b0, done_s}, {31'b0, done});
      if (done) begin
        if (exp_frame.size() == 0) begin
          check("done_without_frame", {31'b0, done}, 0);
        end else begin
          f = exp_frame.pop_front();
          check("count", {22'b0, count}, f.cnt);
          check("overflow", {31'b0, overflow}, f.ov);
          check("count_s", {30'b0, count_s}, f.cnt_s);
          check("overflow_s", {31'b0, overflow_s}, f.ov_s);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", {31'b0, busy}, 0);
      check("idle_done", {31'b0, done}, 0);
      check("idle_count", {22'b0, count}, 0);
      check("idle_overflow", {31'b0, overflow}, 0);
    end

    // Overlapping matches, then gapped valid, then a frame shorter than PW.
    run_frame(4'b1010, 8, 64'b1010_1010, 0, -1, -1);
    check("count_held", {22'b0, count}, 3);
    run_frame(4'b1101, 6, 64'b011011, 1, -1, -1);
    run_frame(4'b1101, 3, 64'b101, 0, -1, -1);

    // Saturation of the 2-bit counter; results hold until the next start.
    run_frame(4'b1111, 10, 64'b11_1111_1111, 0, -1, -1);
    repeat (3) @(negedge clk);
    check("sat_hold_count_s", {30'b0, count_s}, 3);
    check("sat_hold_overflow_s", {31'b0, overflow_s}, 1);
    check("sat_hold_count", {22'b0, count}, 7);

    // Zero-length frame clears the saturated result.
    run_frame(4'b0110, 0, 64'b0, 0, -1, -1);
    check("zero_clears_ov_s", {31'b0, overflow_s}, 0);

    // Start pulsed mid-scan is ignored.
    run_frame(4'b0011, 8, 64'b0011_0011, 0, 3, -1);

    // Reset after 3 of 8 bits, then a clean frame.
    run_frame(4'b1001, 8, 64'b1001_1001, 0, -1, 3);
    run_frame(4'b1001, 8, 64'b1001_1001, 0, -1, -1);

    for (int k = 0; k < 30; k++) begin
      run_frame(PW'($urandom), int'($urandom_range(0, 40)), {$urandom, $urandom},
                int'($urandom_range(0, 2)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1, -1);
    end

    repeat (3) @(negedge clk);
    check("frames_drained", exp_frame.size(), 0);
    check("hits_drained", exp_hit.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
